pseudo_random_gen: RTL and testbench

//  Responder side of the start_pseudo/done_pseudo handshake driven by the reaction-timer FSM.
//  A free-running 16-bit Galois LFSR advances every clock, so the human start time supplies entropy.
//  On a start pulse it mixes for MIX_CYCLES, then returns a 14-bit random_num with a 1-cycle done.

---
 rtl/prng_pkg.sv | 21 ++
 rtl/lfsr16.sv | 24 ++
 rtl/pseudo_random_gen.sv | 100 ++++++++++
 tb/tb_pseudo_random_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and constants for the pseudo-random delay generator.
// Holds the FSM state encoding, LFSR width/polynomial and the single-step LFSR function.
package prng_pkg;

  localparam int LFSR_W = 16;
  localparam int RAND_W = 14;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MIX   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One Galois right-shift step of x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR that steps every clock.
// An all-zero state can never leave itself, so it reloads the seed on the next edge.
module lfsr16
  import prng_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = lfsr_step(q);
    if (q == '0) q_d = seed;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= seed;
    else          q <= q_d;
  end

endmodule

// File: rtl/pseudo_random_gen.sv
// Responder for the start/done random-delay handshake: mixes a free-running LFSR, returns 14 bits.
// Build option RANGE_CHECK_EN adds a CHECK state that retries until the value is in [RAND_MIN, RAND_MAX].
//
// state | meaning
// IDLE  | waiting for start
// MIX   | letting the LFSR run MIX_CYCLES more steps
// CHECK | retrying each cycle until the sample is in range (RANGE_CHECK_EN only)
// DONE  | one-cycle done pulse, random_num valid
module pseudo_random_gen
  import prng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int unsigned       MIX_CYCLES = 16
`ifdef RANGE_CHECK_EN
  ,
  parameter logic [RAND_W-1:0] RAND_MIN   = 14'd2000,
  parameter logic [RAND_W-1:0] RAND_MAX   = 14'd15000
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [RAND_W-1:0] random_num
);

  localparam logic [7:0] MIX_LAST = 8'(MIX_CYCLES - 1);

  logic [LFSR_W-1:0] lfsr_q;
  logic [RAND_W-1:0] sample;
  logic              unused_lfsr_hi;

  state_t            state_q, state_d;
  logic [7:0]        mix_cnt_q, mix_cnt_d;
  logic [RAND_W-1:0] rnum_d;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (SEED),
    .q       (lfsr_q)
  );

  assign sample         = lfsr_q[RAND_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:RAND_W];

  always_comb begin
    state_d   = state_q;
    mix_cnt_d = mix_cnt_q;
    rnum_d    = random_num;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MIX;
          mix_cnt_d = '0;
        end
      end
      MIX: begin
        mix_cnt_d = mix_cnt_q + 8'd1;
        if (mix_cnt_q == MIX_LAST) begin
`ifdef RANGE_CHECK_EN
          state_d = CHECK;
`else
          state_d = DONE;
          rnum_d  = sample;
`endif
        end
      end
`ifdef RANGE_CHECK_EN
      CHECK: begin
        if ((sample >= RAND_MIN) && (sample <= RAND_MAX)) begin
          state_d = DONE;
          rnum_d  = sample;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mix_cnt_q  <= '0;
      random_num <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mix_cnt_q  <= mix_cnt_d;
      random_num <= rnum_d;
      done       <= (state_d == DONE);
      busy       <= (state_d == MIX) || (state_d == CHECK);
    end
  end

endmodule

// File: tb/tb_pseudo_random_gen.sv
// Self-checking bench for pseudo_random_gen: table-driven requests, hand sequences and random spacing.
// The expected random values come from a bench-side LFSR model stepped forward with plain loops.
module tb_pseudo_random_gen;

  localparam int          MIX    = 16;
  localparam logic [15:0] SEED_V = 16'hACE1;
  localparam int          RMIN   = 2000;
  localparam int          RMAX   = 15000;
  localparam int          N_RAND = 1500;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [13:0] random_num;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m;
  logic        inject_zero = 1'b0;

  typedef struct {
    string name;
    int    gap;
    int    pulse_len;
    int    blips;
    int    exp_lat;
    int    exp_busy;
    int    exp_width;
  } vec_t;

  vec_t vec[4];

  pseudo_random_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .random_num (random_num)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] v);
    if (v == 16'h0) return SEED_V;
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic bit in_rng(input logic [13:0] x);
    return (int'(x) >= RMIN) && (int'(x) <= RMAX);
  endfunction

  // Reference LFSR sequence, free-running like the design's.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= SEED_V;
    else          m <= nxt(inject_zero ? 16'h0 : m);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // m0 is the LFSR value in the cycle before the accepting edge.
  task automatic calc(input logic [15:0] m0, output logic [13:0] rn, output int extra);
    logic [15:0] v;
    v = m0;
    for (int i = 0; i < MIX; i++) v = nxt(v);
    extra = 0;
`ifdef RANGE_CHECK_EN
    v     = nxt(v);
    extra = 1;
    while (!in_rng(v[13:0]) && extra < 70000) begin
      v = nxt(v);
      extra++;
    end
`endif
    rn = v[13:0];
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
  task automatic request(input string tag, input int pulse_len, input int blips,
                         input int exp_lat_nom, input int exp_busy_nom, input int exp_width);
    logic [13:0] exp_rn;
    logic [13:0] rn;
    int          extra;
    int          lat;
    int          busy_n;
    int          done_n;
    calc(m, exp_rn, extra);
    start  = 1'b1;
    lat    = -1;
    busy_n = 0;
    done_n = 0;
    rn     = '0;
    for (int k = 1; k <= exp_lat_nom + extra + 1; k++) begin
      @(negedge clk);
      start = (k < pulse_len) || ((k % 2 == 1) && (k >= 3) && (k <= 2 * blips + 1));
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = k;
          rn  = random_num;
        end
      end
    end
    start = 1'b0;
    chk({tag, "_latency"},     lat,             exp_lat_nom + extra);
    chk({tag, "_busy_cycles"}, busy_n,          exp_busy_nom + extra);
    chk({tag, "_done_width"},  done_n,          exp_width);
    chk({tag, "_value"},       int'(rn),        int'(exp_rn));
    chk({tag, "_held"},        int'(random_num), int'(exp_rn));
  endtask

  initial begin
    logic [13:0] exp_rn;
    logic [13:0] rn;
    int          extra;
    int          first;
    int          lat;
    int          nd;
    int          out_cnt;
    int          in_cnt;

    vec[0] = '{"basic",      0, 1,  0, MIX + 1, MIX, 1};
    vec[1] = '{"gap3",       3, 1,  0, MIX + 1, MIX, 1};
    vec[2] = '{"long_start", 1, 6,  0, MIX + 1, MIX, 1};
    vec[3] = '{"mix_blips",  2, 1,  5, MIX + 1, MIX, 1};

    // Reset
    start   = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_done",   int'(done),       0);
    chk("reset_busy",   int'(busy),       0);
    chk("reset_random", int'(random_num), 0);
    reset_n = 1'b1;
    #1;
    chk("reset_lfsr_seed", int'(dut.u_lfsr.q), int'(SEED_V));
    @(negedge clk);

    // Table of single requests
    for (int i = 0; i < 4; i++) begin
      repeat (vec[i].gap) @(negedge clk);
      request(vec[i].name, vec[i].pulse_len, vec[i].blips,
              vec[i].exp_lat, vec[i].exp_busy, vec[i].exp_width);
    end

    // start held high: one idle cycle between responses
    start = 1'b1;
    first = -1;
    for (int k = 1; k <= 60 && first < 0; k++) begin
      @(negedge clk);
      if (done) first = k;
    end
    chk("held_first_done_seen", int'(first > 0), 1);
    @(negedge clk);
    chk("held_gap_busy", int'(busy), 0);
    chk("held_gap_done", int'(done), 0);
    calc(m, exp_rn, extra);
    @(negedge clk);
    chk("held_rebusy", int'(busy), 1);
    start = 1'b0;
    lat   = -1;
    nd    = 0;
    rn    = '0;
    for (int k = 2; k <= MIX + extra + 2; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = k;
          rn  = random_num;
        end
      end
    end
    chk("held_second_latency", lat,      MIX + 1 + extra);
    chk("held_second_value",   int'(rn), int'(exp_rn));
    chk("held_second_width",   nd,       1);

    // Abort with reset in the middle of MIX
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy",   int'(busy),       0);
    chk("abort_done",   int'(done),       0);
    chk("abort_random", int'(random_num), 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_activity", nd, 0);
    request("abort_retry", 1, 0, MIX + 1, MIX, 1);

    // Randomly spaced requests
    out_cnt = 0;
    in_cnt  = 0;
    for (int i = 0; i < N_RAND; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      request("rand", int'($urandom_range(1, 3)), 0, MIX + 1, MIX, 1);
      if (in_rng(random_num)) in_cnt++;
      else                    out_cnt++;
`ifdef RANGE_CHECK_EN
      chk("rand_in_range", int'(in_rng(random_num)), 1);
`endif
    end
`ifdef RANGE_CHECK_EN
    chk("range_all_inside", out_cnt, 0);
`else
    chk("raw_out_of_range_seen", int'(out_cnt > 0), 1);
    chk("raw_in_range_seen",     int'(in_cnt > 0),  1);
`endif

    // Lockup recovery from an all-zero LFSR
    repeat (3) @(negedge clk);
    force dut.u_lfsr.q = 16'h0000;
    inject_zero = 1'b1;
    #1 release dut.u_lfsr.q;
    @(negedge clk);
    inject_zero = 1'b0;
    chk("lockup_reload", int'(dut.u_lfsr.q), int'(SEED_V));
    request("after_lockup", 1, 0, MIX + 1, MIX, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
